traffic_light_monitor: RTL and testbench

Passive checker on the lamp-drive side of the two-road traffic controller. It decodes the one-hot road1/road2 lamp codes and tracks the expected seven-phase sequence, enforcing a maximum dwell per yellow or green phase measured in 1-second ticks. It raises a sticky fault with a first-error code, reports the current phase, and counts completed cycles. It sits beside the controller in the chip top, feeding a fault status output; it never drives the lamps.

---
 rtl/traffic_light_monitor.sv | 161 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive lamp-sequence checker for the two-road traffic controller: tracks the
// seven-phase cycle, enforces per-phase dwell limits and latches the first fault.
module traffic_light_monitor #(
  parameter int CNT_W   = 5,
  parameter int YEL_MAX = 3,
  parameter int GRN_MAX = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] road1_in,
  input  logic [2:0] road2_in,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] phase,
  output logic       cycle_done,
  output logic [7:0] cycle_cnt
);

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_CODE     = 3'd1;
  localparam logic [2:0] ERR_CONFLICT = 3'd2;
  localparam logic [2:0] ERR_SEQ      = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_S1    = 4'd1,
    ST_S2    = 4'd2,
    ST_S3    = 4'd3,
    ST_S4    = 4'd4,
    ST_S5    = 4'd5,
    ST_S6    = 4'd6,
    ST_SYNC  = 4'd7,
    ST_FAULT = 4'd8
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] dwell, dwell_nxt, dwell_inc;
  logic             fault_nxt, done_nxt;
  logic [2:0]       code_nxt, phase_nxt, err;
  logic [7:0]       cnt_nxt;
  logic [5:0]       pair;
  logic             code_bad, conflict, same, adv, limit_hit;

  function automatic logic onehot3(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  // Lamp pair expected while sitting in a sequence state.
  function automatic logic [5:0] exp_pair(input state_t s);
    case (s)
      ST_S1, ST_S3: return {YEL, RED};
      ST_S2:        return {GRN, RED};
      ST_S4, ST_S6: return {RED, YEL};
      ST_S5:        return {RED, GRN};
      default:      return {RED, RED};
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      ST_IDLE: return ST_S1;
      ST_S1:   return ST_S2;
      ST_S2:   return ST_S3;
      ST_S3:   return ST_S4;
      ST_S4:   return ST_S5;
      ST_S5:   return ST_S6;
      default: return ST_IDLE;
    endcase
  endfunction

  assign pair      = {road1_in, road2_in};
  assign code_bad  = !onehot3(road1_in) || !onehot3(road2_in);
  assign conflict  = (road1_in != RED) && (road2_in != RED);
  assign same      = (pair == exp_pair(state));
  assign adv       = (pair == exp_pair(succ(state)));
  assign dwell_inc = (&dwell) ? dwell : dwell + 1'b1;

  always_comb begin
    limit_hit = 1'b0;
    case (state)
      ST_S1, ST_S3, ST_S4, ST_S6: limit_hit = (dwell == CNT_W'(YEL_MAX));
      ST_S2, ST_S5:               limit_hit = (dwell == CNT_W'(GRN_MAX));
      default:                    limit_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    fault_nxt = fault;
    code_nxt  = fault_code;
    done_nxt  = 1'b0;
    cnt_nxt   = cycle_cnt;
    err       = ERR_NONE;
    if (clear) begin
      // clear outranks any error seen on the same edge
      state_nxt = ST_SYNC;
      dwell_nxt = '0;
      fault_nxt = 1'b0;
      code_nxt  = ERR_NONE;
    end else if (state != ST_FAULT) begin
      if (code_bad)      err = ERR_CODE;
      else if (conflict) err = ERR_CONFLICT;
      else if (state == ST_SYNC) begin
        if (pair == {RED, RED}) begin
          state_nxt = ST_IDLE;
          dwell_nxt = '0;
        end else if (tick) begin
          dwell_nxt = dwell_inc;
        end
      end else if (same) begin
        if (tick && limit_hit) err = ERR_TIMEOUT;
        else if (tick)         dwell_nxt = dwell_inc;
      end else if (adv) begin
        // an advance swallows a coincident tick
        state_nxt = succ(state);
        dwell_nxt = '0;
        if (state == ST_S6) begin
          done_nxt = 1'b1;
          cnt_nxt  = cycle_cnt + 8'd1;
        end
      end else begin
        err = ERR_SEQ;
      end
      if (err != ERR_NONE) begin
        state_nxt = ST_FAULT;
        fault_nxt = 1'b1;
        code_nxt  = err;
      end
    end
    phase_nxt = (state_nxt == ST_FAULT) ? 3'd7 : state_nxt[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SYNC;
      dwell      <= '0;
      fault      <= 1'b0;
      fault_code <= ERR_NONE;
      phase      <= 3'd7;
      cycle_done <= 1'b0;
      cycle_cnt  <= 8'd0;
    end else begin
      state      <= state_nxt;
      dwell      <= dwell_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
      phase      <= phase_nxt;
      cycle_done <= done_nxt;
      cycle_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios plus random
// lamp traffic, checked against a table-driven phase model.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] road1_in = 3'b001;
  logic [2:0] road2_in = 3'b001;
  logic       clear = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] phase;
  logic       cycle_done;
  logic [7:0] cycle_cnt;

  traffic_light_monitor #(.CNT_W(5), .YEL_MAX(3), .GRN_MAX(11)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .road1_in(road1_in), .road2_in(road2_in),
    .clear(clear), .fault(fault), .fault_code(fault_code), .phase(phase),
    .cycle_done(cycle_done), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       fault;
    logic [2:0] code;
    logic       done;
    logic [7:0] cnt;
  } obs_t;

  localparam logic [5:0] RR = 6'b001_001, YR = 6'b010_001, GR = 6'b100_001;
  localparam logic [5:0] RY = 6'b001_010, RG = 6'b001_100, GG = 6'b100_100;

  // Lamp pair of each sequence step 0..6; model state 7 = resync, 8 = faulted.
  logic [5:0] lamp [0:6] = '{RR, YR, GR, YR, RY, RG, RY};

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_state, m_dwell, m_code, m_cnt;
  logic m_fault, m_done;

  function automatic int limit_of(input int s);
    if (s == 1 || s == 3 || s == 4 || s == 6) return 3;
    if (s == 2 || s == 5) return 11;
    return -1;
  endfunction

  function automatic logic legal(input logic [2:0] c);
    return c == 3'b001 || c == 3'b010 || c == 3'b100;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.phase = (m_state == 8) ? 3'd7 : 3'(m_state);
    o.fault = m_fault;
    o.code  = 3'(m_code);
    o.done  = m_done;
    o.cnt   = 8'(m_cnt);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.phase = phase; o.fault = fault; o.code = fault_code;
    o.done  = cycle_done; o.cnt = cycle_cnt;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 7; m_dwell = 0; m_code = 0; m_cnt = 0; m_fault = 0; m_done = 0;
  endtask

  task automatic model_step(input logic [5:0] p, input logic tk, input logic cl);
    int err = 0;
    m_done = 0;
    if (cl) begin
      m_state = 7; m_dwell = 0; m_fault = 0; m_code = 0;
    end else if (m_state != 8) begin
      if (!legal(p[5:3]) || !legal(p[2:0])) err = 1;
      else if (p[5:3] != 3'b001 && p[2:0] != 3'b001) err = 2;
      else if (m_state == 7) begin
        if (p == RR) begin m_state = 0; m_dwell = 0; end
        else if (tk && m_dwell < 31) m_dwell++;
      end else if (p == lamp[m_state]) begin
        if (tk && m_dwell == limit_of(m_state)) err = 4;
        else if (tk && m_dwell < 31) m_dwell++;
      end else if (p == lamp[(m_state + 1) % 7]) begin
        if (m_state == 6) begin m_done = 1; m_cnt = (m_cnt + 1) % 256; end
        m_state = (m_state + 1) % 7;
        m_dwell = 0;
      end else err = 3;
      if (err != 0) begin m_state = 8; m_fault = 1; m_code = err; end
    end
  endtask

  task automatic check(input string name, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got phase=%0d fault=%0d code=%0d done=%0d cnt=%0d, want phase=%0d fault=%0d code=%0d done=%0d cnt=%0d",
               name, a.phase, a.fault, a.code, a.done, a.cnt, e.phase, e.fault, e.code, e.done, e.cnt);
    end
  endtask

  // Monitor: every edge's registered outputs are checked one half-period later.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("step", dut_obs(), exp_q.pop_front());
  end

  task automatic drive(input logic [5:0] p, input logic tk, input logic cl, input logic rn = 1'b1);
    @(negedge clk); #1;
    {road1_in, road2_in} = p;
    tick = tk; clear = cl; rst_n = rn;
    if (!rn) begin
      model_reset();
      #1 check("async_reset", dut_obs(), model_obs());
    end else model_step(p, tk, cl);
    exp_q.push_back(model_obs());
  endtask

  task automatic hold(input logic [5:0] p, input int ticks);
    drive(p, 1'b0, 1'b0);
    for (int k = 0; k < ticks; k++) drive(p, 1'b1, 1'b0);
  endtask

  task automatic legal_cycle();
    hold(YR, 1); hold(GR, 10); hold(YR, 2); hold(RY, 2);
    hold(RG, 10); hold(RY, 2); hold(RR, 0);
  endtask

  initial begin
    logic [5:0] pr, cur, nxt;
    logic       tk, cl, rn;
    int         pick;
    model_reset();
    drive(RR, 0, 0, 0); drive(RR, 0, 0, 0);
    repeat (3) drive(RR, 0, 0);
    legal_cycle();
    // green overstay
    hold(YR, 0); hold(GR, 12);
    drive(RR, 0, 1); drive(RR, 0, 0);
    // conflict, then a later code error must not overwrite it
    drive(GG, 0, 0); drive({3'b011, 3'b001}, 0, 0);
    drive(RR, 0, 1); drive(RR, 0, 0);
    // skipped phase, clear with R/R present
    hold(YR, 0); hold(GR, 0); drive(RG, 0, 0);
    drive(RR, 0, 1); drive(RR, 0, 0);
    // tick coincident with advance, then wrap the cycle counter
    hold(YR, 1); drive(GR, 1, 0);
    hold(GR, 3); hold(YR, 1); hold(RY, 1); hold(RG, 2); hold(RY, 1); hold(RR, 0);
    for (int c = 0; c < 256; c++) begin
      hold(YR, 0); hold(GR, 0); hold(YR, 0); hold(RY, 0);
      hold(RG, 0); hold(RY, 0); hold(RR, 0);
    end
    // bad code under clear
    drive(6'b001_000, 0, 1);
    drive(RR, 0, 0);
    legal_cycle();
    for (int i = 0; i < 4000; i++) begin
      pick = $urandom_range(0, 999);
      tk = ($urandom_range(0, 2) == 0);
      cl = 1'b0; rn = 1'b1;
      cur = (m_state < 7) ? lamp[m_state] : RR;
      nxt = (m_state < 7) ? lamp[(m_state + 1) % 7] : RR;
      pr = cur;
      if (m_state == 8) cl = (pick < 150);
      else if (pick < 700) pr = cur;
      else if (pick < 880) pr = nxt;
      else if (pick < 920) pr = 6'($urandom);
      else if (pick < 960) pr = lamp[$urandom_range(0, 6)];
      else if (pick < 995) begin cl = 1'b1; pr = 6'($urandom); end
      else rn = 1'b0;
      drive(pr, tk, cl, rn);
    end
    @(negedge clk); #1;
    drive(RR, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
